// File: rtl/cursor_serial_rx_if.sv
// Bundle between the Arduino GPIO header and the cursor receiver: raw pins in,
// accepted coordinates and frame status out.
interface cursor_serial_rx_if;
    logic [35:0] GPIO;
    logic [9:0]  xCoordinate;
    logic [9:0]  yCoordinate;
    logic        coord_valid;
    logic        frame_err;
    logic [7:0]  err_count;

    modport master (
        output GPIO,
        input  xCoordinate, yCoordinate, coord_valid, frame_err, err_count
    );

    modport slave (
        input  GPIO,
        output xCoordinate, yCoordinate, coord_valid, frame_err, err_count
    );
endinterface

// File: rtl/cursor_serial_rx.sv
// Receives 24-bit cursor packets over the Arduino serial link, validates them,
// clamps to the 640x480 screen and holds the last good position.
module cursor_serial_rx #(
    parameter int SCLK_BIT       = 8,
    parameter int DATA_BIT       = 9,
    parameter int CS_N_BIT       = 10,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    cursor_serial_rx_if.slave  bus
);
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WAIT_END} state_t;

    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Synchronisers are left unreset so a reset in mid-frame never fakes a cs_n edge.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic data_s1, data_s2;
    logic cs_s1, cs_s2, cs_s3;

    always_ff @(posedge clk) begin
        sclk_s1 <= bus.GPIO[SCLK_BIT];
        sclk_s2 <= sclk_s1;
        sclk_s3 <= sclk_s2;
        data_s1 <= bus.GPIO[DATA_BIT];
        data_s2 <= data_s1;
        cs_s1   <= bus.GPIO[CS_N_BIT];
        cs_s2   <= cs_s1;
        cs_s3   <= cs_s2;
    end

    logic unused_gpio;
    assign unused_gpio = ^bus.GPIO;

    logic sclk_rise, cs_fall, cs_rise;
    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign cs_fall   = ~cs_s2 & cs_s3;
    assign cs_rise   = cs_s2 & ~cs_s3;

    state_t           state_q;
    logic [23:0]      shift_q, shift_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0] tmo_q;
    logic [9:0]       x_q, y_q, x_d, y_d;
    logic             coord_valid_q, frame_err_q;
    logic [7:0]       err_count_q;
    logic             frame_ok;

    assign shift_d   = {shift_q[22:0], data_s2};
    assign bit_cnt_d = bit_cnt_q + 5'd1;
    assign x_d       = clamp10(shift_q[21:12], 10'd639);
    assign y_d       = clamp10(shift_q[11:2], 10'd479);
    // Sync 2'b10, even parity over X, Y and the parity bit itself, stop bit low.
    assign frame_ok  = (shift_q[23:22] == 2'b10) && !(^shift_q[21:1]) && !shift_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tmo_q         <= '0;
            x_q           <= 10'd320;
            y_q           <= 10'd240;
            coord_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            coord_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        tmo_q     <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                        tmo_q     <= '0;
                        if (bit_cnt_d == 5'd24) begin
                            state_q <= CHECK;
                        end else if (cs_rise) begin
                            frame_err_q <= 1'b1;
                            err_count_q <= sat_inc8(err_count_q);
                            state_q     <= IDLE;
                        end
                    end else if (cs_rise || tmo_q == TMO_LAST) begin
                        frame_err_q <= 1'b1;
                        err_count_q <= sat_inc8(err_count_q);
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                CHECK: begin
                    if (frame_ok) begin
                        x_q           <= x_d;
                        y_q           <= y_d;
                        coord_valid_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                        err_count_q <= sat_inc8(err_count_q);
                    end
                    state_q <= cs_s2 ? IDLE : WAIT_END;
                end
                WAIT_END: begin
                    if (cs_rise) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.xCoordinate = x_q;
    assign bus.yCoordinate = y_q;
    assign bus.coord_valid = coord_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.err_count   = err_count_q;
endmodule
